// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the pipelined datapath.
//
// Holds NREGS general registers (register 0 hardwired to zero), a hi/lo
// pair for mult/div results, and a per-register pending scoreboard used by
// the hazard unit to stall on multi-cycle producers.
//
// Ports:
//   clock, reset             rising-edge clock; asynchronous active-high reset
//   rd_en    [NREAD]         per-port read enable; 0 holds rd_data/rd_busy
//   rd_addr  [NREAD*AW]      read address, port p at [p*AW +: AW]
//   rd_data  [NREAD*XLEN]    registered read data, write-forwarded
//   rd_busy  [NREAD]         registered pending bit of the addressed register
//   wr_en    [NWRITE]        per-port write enable, higher index wins
//   wr_addr  [NWRITE*AW]     write addresses
//   wr_data  [NWRITE*XLEN]   write data
//   hilo_we, hilo_data       write {hi, lo}
//   hi_out, lo_out           registered hi/lo
//   hilo_busy                hi/lo pending
//   sb_set, sb_addr          mark a register pending at producer issue
//   hilo_set                 mark hi/lo pending
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREAD-1:0]         rd_en,
    input  logic [NREAD*AW-1:0]      rd_addr,
    output logic [NREAD*XLEN-1:0]    rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*AW-1:0]     wr_addr,
    input  logic [NWRITE*XLEN-1:0]   wr_data,
    input  logic                     hilo_we,
    input  logic [2*XLEN-1:0]        hilo_data,
    output logic [XLEN-1:0]          hi_out,
    output logic [XLEN-1:0]          lo_out,
    output logic                     hilo_busy,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr,
    input  logic                     hilo_set
);

    logic [XLEN-1:0] regs      [NREGS];
    logic [XLEN-1:0] next_regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] next_pending;

    // Next-state view of the array and scoreboard after this edge. Reads
    // index this view, which gives same-edge forwarding with exactly the
    // same priority resolution as the write itself.
    always_comb begin
        // NOTE: every comb output gets a full default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_regs    = regs;
        next_pending = pending;
        // Ascending port order: a higher-index port to the same address
        // overwrites the lower one, which implements the priority.
        for (int p = 0; p < NWRITE; p++) begin
            if (wr_en[p]) begin
                next_regs[wr_addr[p*AW +: AW]]    = wr_data[p*XLEN +: XLEN];
                next_pending[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        // Applied after the clears so a same-edge set wins.
        if (sb_set) begin
            next_pending[sb_addr] = 1'b1;
        end
        // Register 0 is never written, pending or forwarded.
        next_regs[0]    = '0;
        next_pending[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the register array is built from resettable flops,
            // not a RAM macro, because every register must clear on reset.
            regs      <= '{default: '0};
            pending   <= '0;
            rd_data   <= '0;
            rd_busy   <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
            hilo_busy <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            regs    <= next_regs;
            pending <= next_pending;

            for (int p = 0; p < NREAD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p*XLEN +: XLEN] <= next_regs[rd_addr[p*AW +: AW]];
                    rd_busy[p]              <= next_pending[rd_addr[p*AW +: AW]];
                end
            end

            // hi/lo storage doubles as the output register: a write shows
            // on hi_out/lo_out right after the writing edge.
            if (hilo_we) begin
                hi_out <= hilo_data[2*XLEN-1:XLEN];
                lo_out <= hilo_data[XLEN-1:0];
            end

            if (hilo_set) begin
                hilo_busy <= 1'b1;
            end else if (hilo_we) begin
                hilo_busy <= 1'b0;
            end
        end
    end

endmodule
